// File: rtl/kbd_source_arbiter_if.sv
// kbd_source_arbiter_if: keyboard source strobes, CPU read port and status outputs of the arbiter
interface kbd_source_arbiter_if #(parameter int CNT_W = 3);
    logic [7:0]       uart_data;
    logic             uart_strobe;
    logic [7:0]       ps2_data;
    logic             ps2_strobe;
    logic             cs;
    logic             addr;
    logic             rd_en;
    logic [7:0]       dout;
    logic             key_ready;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    modport master (
        output uart_data, uart_strobe, ps2_data, ps2_strobe, cs, addr, rd_en,
        input  dout, key_ready, fifo_count, overflow
    );
    modport slave (
        input  uart_data, uart_strobe, ps2_data, ps2_strobe, cs, addr, rd_en,
        output dout, key_ready, fifo_count, overflow
    );
endinterface

// File: rtl/kbd_source_arbiter.sv
// kbd_source_arbiter: merges UART and PS/2 key bytes round-robin into a FIFO read through KBD/KBDCR
module kbd_source_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input logic           clk25,
    input logic           rst_n,
    kbd_source_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {SRC_UART, SRC_PS2} src_t;
    src_t             last_grant;
    logic             pend_u, pend_p;
    logic [7:0]       hold_u, hold_p;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       dout;
    logic             overflow;
    logic             full, empty, grant_u, grant_p, push, pop, rd, ovf_set;
    // Apple 1 form: bit 7 set, lowercase folded to uppercase
    function automatic logic [7:0] norm(input logic [7:0] d);
        return (d | 8'h80) - ((d[6:0] >= 7'h61 && d[6:0] <= 7'h7A) ? 8'h20 : 8'h00);
    endfunction
    assign full    = count == CNT_W'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign grant_p = pend_p && !full && (!pend_u || last_grant == SRC_UART);
    assign grant_u = pend_u && !full && !grant_p;
    assign push    = grant_u || grant_p;
    assign rd      = bus.cs && bus.rd_en;
    assign pop     = rd && !bus.addr && !empty;
    assign ovf_set = (bus.uart_strobe && pend_u && !grant_u) || (bus.ps2_strobe && pend_p && !grant_p);
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            pend_u     <= 1'b0;
            pend_p     <= 1'b0;
            hold_u     <= 8'h00;
            hold_p     <= 8'h00;
            last_grant <= SRC_UART;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            if (bus.uart_strobe && (!pend_u || grant_u)) begin
                hold_u <= norm(bus.uart_data);
                pend_u <= 1'b1;
            end else if (grant_u) begin
                pend_u <= 1'b0;
            end
            if (bus.ps2_strobe && (!pend_p || grant_p)) begin
                hold_p <= norm(bus.ps2_data);
                pend_p <= 1'b1;
            end else if (grant_p) begin
                pend_p <= 1'b0;
            end
            if (push) begin
                last_grant <= grant_p ? SRC_PS2 : SRC_UART;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (rd)
                dout <= bus.addr ? {!empty, 6'b0, overflow} : (empty ? 8'h00 : mem[rd_ptr]);
            overflow <= ovf_set || (overflow && !(rd && bus.addr));
        end
    end
    always_ff @(posedge clk25)
        if (rst_n && push)
            mem[wr_ptr] <= grant_p ? hold_p : hold_u;
    assign bus.dout       = dout;
    assign bus.key_ready  = !empty;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_kbd_source_arbiter.sv
// tb_kbd_source_arbiter: directed vectors with hand-computed expectations for kbd_source_arbiter
module tb_kbd_source_arbiter;
    logic clk25 = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    kbd_source_arbiter_if #(.CNT_W(3)) bus ();
    kbd_source_arbiter #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );
    always #20 clk25 = ~clk25;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk25);
    endtask
    // one cycle of stimulus: inputs held across a single rising edge, then released
    task automatic drive(input logic us, input logic [7:0] ud, input logic ps, input logic [7:0] pd,
                         input logic r, input logic a);
        bus.uart_strobe = us;
        bus.uart_data   = ud;
        bus.ps2_strobe  = ps;
        bus.ps2_data    = pd;
        bus.cs          = r;
        bus.rd_en       = r;
        bus.addr        = a;
        @(negedge clk25);
        bus.uart_strobe = 1'b0;
        bus.ps2_strobe  = 1'b0;
        bus.cs          = 1'b0;
        bus.rd_en       = 1'b0;
        bus.addr        = 1'b0;
    endtask
    task automatic kbd_read(input string tag, input logic [7:0] exp_d, input int exp_cnt);
        drive(0, 8'h00, 0, 8'h00, 1, 0);
        chk({tag, "_dout"}, 32'(bus.dout), 32'(exp_d));
        chk({tag, "_cnt"}, 32'(bus.fifo_count), 32'(exp_cnt));
    endtask
    initial begin
        rst_n = 1'b0;
        bus.uart_strobe = 1'b0;
        bus.uart_data   = 8'h00;
        bus.ps2_strobe  = 1'b0;
        bus.ps2_data    = 8'h00;
        bus.cs          = 1'b0;
        bus.rd_en       = 1'b0;
        bus.addr        = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        chk("rst_dout", 32'(bus.dout), 32'h00);
        chk("rst_ready", 32'(bus.key_ready), 32'h0);
        chk("rst_cnt", 32'(bus.fifo_count), 32'h0);
        chk("rst_ovf", 32'(bus.overflow), 32'h0);
        drive(1, 8'h61, 0, 8'h00, 0, 0);
        wait_cyc(3);
        chk("t1_ready", 32'(bus.key_ready), 32'h1);
        chk("t1_cnt", 32'(bus.fifo_count), 32'h1);
        kbd_read("t1_rd", 8'hC1, 0);
        chk("t1_ready_after", 32'(bus.key_ready), 32'h0);
        drive(1, 8'h41, 1, 8'h42, 0, 0);
        wait_cyc(3);
        chk("t2_cnt", 32'(bus.fifo_count), 32'h2);
        kbd_read("t2_rd0", 8'hC2, 1);
        kbd_read("t2_rd1", 8'hC1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'h31 + i), 0, 8'h00, 0, 0);
            wait_cyc(2);
        end
        chk("t3_cnt", 32'(bus.fifo_count), 32'h4);
        chk("t3_ovf", 32'(bus.overflow), 32'h1);
        drive(0, 8'h00, 0, 8'h00, 1, 1);
        chk("t3_cr_dout", 32'(bus.dout), 32'h81);
        chk("t3_cr_ovf", 32'(bus.overflow), 32'h0);
        kbd_read("t3_rd", 8'hB1, 3);
        wait_cyc(1);
        chk("t3_refill_cnt", 32'(bus.fifo_count), 32'h4);
        drive(0, 8'h00, 1, 8'h50, 0, 0);
        drive(0, 8'h00, 1, 8'h51, 0, 0);
        chk("t4_ovf", 32'(bus.overflow), 32'h1);
        drive(0, 8'h00, 1, 8'h52, 1, 1);
        chk("t4_cr_dout", 32'(bus.dout), 32'h81);
        chk("t4_set_wins", 32'(bus.overflow), 32'h1);
        drive(0, 8'h00, 0, 8'h00, 1, 1);
        chk("t4_cr2_dout", 32'(bus.dout), 32'h81);
        chk("t4_cr2_ovf", 32'(bus.overflow), 32'h0);
        kbd_read("t4_d0", 8'hB2, 3);
        kbd_read("t4_d1", 8'hB3, 3);
        kbd_read("t4_d2", 8'hB4, 2);
        kbd_read("t4_d3", 8'hB5, 1);
        kbd_read("t4_d4", 8'hD0, 0);
        kbd_read("t5_empty", 8'h00, 0);
        drive(1, 8'h7A, 0, 8'h00, 0, 0);
        kbd_read("t5_rd_push", 8'h00, 1);
        chk("t5_ready", 32'(bus.key_ready), 32'h1);
        kbd_read("t5_rd_next", 8'hDA, 0);
        drive(1, 8'hE1, 1, 8'h7B, 0, 0);
        wait_cyc(2);
        kbd_read("n_rd0", 8'hFB, 1);
        kbd_read("n_rd1", 8'hC1, 0);
        drive(1, 8'h60, 0, 8'h00, 0, 0);
        wait_cyc(2);
        kbd_read("n_rd2", 8'hE0, 0);
        drive(1, 8'h7B, 0, 8'h00, 0, 0);
        wait_cyc(2);
        drive(1, 8'h60, 0, 8'h00, 0, 0);
        wait_cyc(2);
        chk("t6_cnt", 32'(bus.fifo_count), 32'h2);
        drive(0, 8'h00, 0, 8'h00, 1, 1);
        chk("t6_cr_dout", 32'(bus.dout), 32'h80);
        drive(1, 8'h33, 0, 8'h00, 0, 0);
        rst_n = 1'b0;
        bus.uart_strobe = 1'b1;
        bus.uart_data   = 8'h34;
        @(negedge clk25);
        rst_n = 1'b1;
        bus.uart_strobe = 1'b0;
        chk("t6_rst_cnt", 32'(bus.fifo_count), 32'h0);
        chk("t6_rst_ready", 32'(bus.key_ready), 32'h0);
        chk("t6_rst_dout", 32'(bus.dout), 32'h00);
        chk("t6_rst_ovf", 32'(bus.overflow), 32'h0);
        wait_cyc(3);
        chk("t6_no_pending", 32'(bus.fifo_count), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
